// File: rtl/lane_dly_step_seq.sv
// -----------------------------------------------------------------------------
// lane_dly_step_seq
//
// Sequencer in front of one DDR3 PHY lane controller, on the fabric clock.
// Turns single-shot delay-line requests from read/write training into paced
// handshakes on the lane's delay-line ports. The HS I/O clock is paused around
// every adjustment. RX and TX tap positions are shadowed locally, and any
// saturated, out-of-range or reserved request is flagged on completion.
//
// Ports
//   FAB_CLK                     in   fabric clock, rising edge
//   RESET                       in   asynchronous reset, active-high
//   req_valid / req_ready       in/out request handshake (ready only when idle)
//   req_op                      in   00 step, 01 load, 1x reserved
//   req_sel                     in   0 RX line, 1 TX line
//   req_dir                     in   1 increment, 0 decrement
//   req_count                   in   number of MOVE steps for a step op
//   done / err                  out  1-cycle completion pulse / error with done
//   tap_rx / tap_tx             out  RX / TX tap shadows
//   DELAY_LINE_SEL / DIRECTION  out  latched sel / dir, held until the next request
//   DELAY_LINE_MOVE / LOAD      out  1-cycle step / load pulses
//   HS_IO_CLK_PAUSE             out  clock pause request to the lane controller
//   RX/TX_DELAY_LINE_OUT_OF_RANGE in out-of-range flags from the lane controller
// -----------------------------------------------------------------------------
module lane_dly_step_seq #(
  parameter int unsigned TAP_W       = 7,
  parameter int unsigned TAP_MAX     = 127,
  parameter int unsigned INIT_TAP    = 1,
  parameter int unsigned PAUSE_SETUP = 2,
  parameter int unsigned MOVE_GAP    = 3,
  parameter int unsigned PAUSE_HOLD  = 2
) (
  input  logic             FAB_CLK,
  input  logic             RESET,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic             req_sel,
  input  logic             req_dir,
  input  logic [5:0]       req_count,
  output logic             done,
  output logic             err,
  output logic [TAP_W-1:0] tap_rx,
  output logic [TAP_W-1:0] tap_tx,
  output logic             DELAY_LINE_SEL,
  output logic             DELAY_LINE_DIRECTION,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_LOAD,
  output logic             HS_IO_CLK_PAUSE,
  input  logic             RX_DELAY_LINE_OUT_OF_RANGE,
  input  logic             TX_DELAY_LINE_OUT_OF_RANGE
);

  localparam int unsigned TMR_W = 8;

  localparam logic [TAP_W-1:0] LP_TAP_MAX  = TAP_W'(TAP_MAX);
  localparam logic [TAP_W-1:0] LP_INIT_TAP = TAP_W'(INIT_TAP);
  localparam logic [TMR_W-1:0] LP_SETUP_END = TMR_W'(PAUSE_SETUP - 1);
  localparam logic [TMR_W-1:0] LP_GAP_END   = TMR_W'(MOVE_GAP - 1);
  localparam logic [TMR_W-1:0] LP_HOLD_END  = TMR_W'(PAUSE_HOLD - 1);

  localparam logic [1:0] OP_STEP = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StGap,
    StHold,
    StFin
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic [1:0]       r_op;
  logic             r_sel;
  logic             r_dir;
  logic [5:0]       r_cnt;     // steps still to issue, including the pending one
  logic [TMR_W-1:0] r_tmr;     // cycles spent in the current state
  logic             r_err;
  logic             r_sat;     // registered copy of w_sat
  logic [TAP_W-1:0] r_tap_rx;
  logic [TAP_W-1:0] r_tap_tx;

  logic             w_accept;
  logic             w_is_step;
  logic             w_is_load;
  logic [TAP_W-1:0] w_tap_cur;
  logic             w_sat;
  logic             w_oor;
  logic             w_move;
  logic             w_load;

  assign w_accept  = req_valid && (r_state == StIdle);
  assign w_is_step = (r_op == OP_STEP);
  assign w_is_load = (r_op == OP_LOAD);
  assign w_tap_cur = r_sel ? r_tap_tx : r_tap_rx;
  // Next step in the latched direction would leave the legal tap range.
  assign w_sat     = r_dir ? (w_tap_cur == LP_TAP_MAX) : (w_tap_cur == '0);
  assign w_oor     = r_sel ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;
  assign w_move    = (r_state == StPulse) && w_is_step && !w_sat;
  assign w_load    = (r_state == StPulse) && w_is_load;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          if (req_op == OP_LOAD) begin
            w_state_nxt = StSetup;
          end else if ((req_op == OP_STEP) && (req_count != '0)) begin
            w_state_nxt = StSetup;
          end else begin
            // Zero-count step or reserved op: complete without pausing.
            w_state_nxt = StFin;
          end
        end
      end
      StSetup: begin
        if (r_tmr == LP_SETUP_END) w_state_nxt = StPulse;
      end
      StPulse: begin
        if (w_is_load || w_sat || (r_cnt == 6'd1)) begin
          w_state_nxt = StHold;
        end else begin
          w_state_nxt = StGap;
        end
      end
      StGap: begin
        // r_sat lags the tap by a cycle, so a gap releases into HOLD from its
        // second cycle once the last move has hit the end of the line.
        if (r_sat) begin
          w_state_nxt = StHold;
        end else if (r_tmr == LP_GAP_END) begin
          w_state_nxt = StPulse;
        end
      end
      StHold: begin
        if (r_tmr == LP_HOLD_END) w_state_nxt = StFin;
      end
      StFin: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM outputs (decoded from the state register so reset clears them at once)
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready       = 1'b0;
    done            = 1'b0;
    err             = 1'b0;
    HS_IO_CLK_PAUSE = 1'b0;
    DELAY_LINE_MOVE = 1'b0;
    DELAY_LINE_LOAD = 1'b0;
    unique case (r_state)
      StIdle: begin
        req_ready = 1'b1;
      end
      StSetup, StGap, StHold: begin
        HS_IO_CLK_PAUSE = 1'b1;
      end
      StPulse: begin
        HS_IO_CLK_PAUSE = 1'b1;
        DELAY_LINE_MOVE = w_move;
        DELAY_LINE_LOAD = w_load;
      end
      StFin: begin
        done = 1'b1;
        err  = r_err;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch, timers, step counter, error flag and tap shadows
  // ---------------------------------------------------------------------------
  always_ff @(posedge FAB_CLK or posedge RESET) begin
    if (RESET) begin
      r_op     <= OP_STEP;
      r_sel    <= 1'b0;
      r_dir    <= 1'b0;
      r_cnt    <= '0;
      r_tmr    <= '0;
      r_err    <= 1'b0;
      r_sat    <= 1'b0;
      r_tap_rx <= LP_INIT_TAP;
      r_tap_tx <= LP_INIT_TAP;
    end else begin
      r_sat <= w_sat;
      r_tmr <= (w_state_nxt != r_state) ? '0 : r_tmr + 1'b1;

      if (w_accept) begin
        r_op  <= req_op;
        r_sel <= req_sel;
        r_dir <= req_dir;
        r_cnt <= req_count;
        r_err <= req_op[1];
      end

      if (w_move) begin
        r_cnt <= r_cnt - 1'b1;
        if (r_sel) begin
          r_tap_tx <= r_dir ? r_tap_tx + 1'b1 : r_tap_tx - 1'b1;
        end else begin
          r_tap_rx <= r_dir ? r_tap_rx + 1'b1 : r_tap_rx - 1'b1;
        end
      end

      if (w_load) begin
        if (r_sel) begin
          r_tap_tx <= LP_INIT_TAP;
        end else begin
          r_tap_rx <= LP_INIT_TAP;
        end
      end

      if ((r_state == StPulse) && w_is_step && w_sat) begin
        r_err <= 1'b1;
      end

      if (r_state == StGap) begin
        if (r_sat) begin
          r_err <= 1'b1;
        end
        // The move already scheduled at the end of this gap still goes out;
        // everything after it is dropped.
        if (w_oor) begin
          r_err <= 1'b1;
          if (r_cnt > 6'd1) r_cnt <= 6'd1;
        end
      end
    end
  end

  assign tap_rx               = r_tap_rx;
  assign tap_tx               = r_tap_tx;
  assign DELAY_LINE_SEL       = r_sel;
  assign DELAY_LINE_DIRECTION = r_dir;

endmodule

// File: tb/tb_lane_dly_step_seq.sv
// Directed bench for lane_dly_step_seq. Each request is captured as per-cycle
// bit masks (bit c = cycle c after the accepting edge) and compared against
// hand-computed constants.
module tb_lane_dly_step_seq;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic       req_sel;
  logic       req_dir;
  logic [5:0] req_count;
  logic       done;
  logic       err;
  logic [6:0] tap_rx;
  logic [6:0] tap_tx;
  logic       dl_sel;
  logic       dl_dir;
  logic       dl_move;
  logic       dl_load;
  logic       pause;
  logic       rx_oor;
  logic       tx_oor;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] m_pause;
  logic [63:0] m_move;
  logic [63:0] m_load;
  logic [63:0] m_done;
  logic        err_at_done;

  lane_dly_step_seq dut (
    .FAB_CLK                    (clk),
    .RESET                      (rst),
    .req_valid                  (req_valid),
    .req_ready                  (req_ready),
    .req_op                     (req_op),
    .req_sel                    (req_sel),
    .req_dir                    (req_dir),
    .req_count                  (req_count),
    .done                       (done),
    .err                        (err),
    .tap_rx                     (tap_rx),
    .tap_tx                     (tap_tx),
    .DELAY_LINE_SEL             (dl_sel),
    .DELAY_LINE_DIRECTION       (dl_dir),
    .DELAY_LINE_MOVE            (dl_move),
    .DELAY_LINE_LOAD            (dl_load),
    .HS_IO_CLK_PAUSE            (pause),
    .RX_DELAY_LINE_OUT_OF_RANGE (rx_oor),
    .TX_DELAY_LINE_OUT_OF_RANGE (tx_oor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issue one request and record 40 cycles of strobes. rx_oor is raised for
  // the single cycle oor_cyc (negative: never).
  task automatic do_req(input logic [1:0] op, input logic sel, input logic dir,
                        input logic [5:0] cnt, input int oor_cyc);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) check_eq("ready_wait", 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    req_op    = op;
    req_sel   = sel;
    req_dir   = dir;
    req_count = cnt;
    @(posedge clk);
    #1 req_valid = 1'b0;
    m_pause     = '0;
    m_move      = '0;
    m_load      = '0;
    m_done      = '0;
    err_at_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      m_pause[c] = pause;
      m_move[c]  = dl_move;
      m_load[c]  = dl_load;
      m_done[c]  = done;
      if (done) err_at_done = err;
      rx_oor = (c == oor_cyc);
    end
    rx_oor = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int done_seen;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_sel   = 1'b0;
    req_dir   = 1'b0;
    req_count = '0;
    rx_oor    = 1'b0;
    tx_oor    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check_eq("rst_ready", 64'(req_ready), 64'(1));
    check_eq("rst_tap_rx", 64'(tap_rx), 64'(1));
    check_eq("rst_tap_tx", 64'(tap_tx), 64'(1));
    check_eq("rst_strobes", 64'({done, err, dl_sel, dl_dir, dl_move, dl_load, pause}), 64'(0));

    // Step RX up by 3
    do_req(2'b00, 1'b0, 1'b1, 6'd3, -1);
    check_eq("up3_pause", m_pause, 64'h1FFF);
    check_eq("up3_move", m_move, 64'h444);
    check_eq("up3_load", m_load, 64'h0);
    check_eq("up3_done", m_done, 64'h2000);
    check_eq("up3_err", 64'(err_at_done), 64'(0));
    check_eq("up3_tap_rx", 64'(tap_rx), 64'(4));
    check_eq("up3_dir_held", 64'(dl_dir), 64'(1));

    // Raise TX to 9 with 8 steps
    do_req(2'b00, 1'b1, 1'b1, 6'd8, -1);
    check_eq("up8_move", m_move, 64'h4444_4444);
    check_eq("up8_done", m_done, 64'h2_0000_0000);
    check_eq("up8_tap_tx", 64'(tap_tx), 64'(9));

    // Load TX
    do_req(2'b01, 1'b1, 1'b0, 6'd0, -1);
    check_eq("ldtx_pause", m_pause, 64'h1F);
    check_eq("ldtx_load", m_load, 64'h4);
    check_eq("ldtx_move", m_move, 64'h0);
    check_eq("ldtx_done", m_done, 64'h20);
    check_eq("ldtx_err", 64'(err_at_done), 64'(0));
    check_eq("ldtx_tap_tx", 64'(tap_tx), 64'(1));
    check_eq("ldtx_sel_held", 64'(dl_sel), 64'(1));

    // Load RX back to 1
    do_req(2'b01, 1'b0, 1'b0, 6'd0, -1);
    check_eq("ldrx_tap_rx", 64'(tap_rx), 64'(1));

    // Step RX down by 5 from 1: saturates after one move
    do_req(2'b00, 1'b0, 1'b0, 6'd5, -1);
    check_eq("sat_move", m_move, 64'h4);
    check_eq("sat_pause", m_pause, 64'h7F);
    check_eq("sat_done", m_done, 64'h80);
    check_eq("sat_err", 64'(err_at_done), 64'(1));
    check_eq("sat_tap_rx", 64'(tap_rx), 64'(0));

    // Step RX up by 4 with out-of-range raised in cycle 4
    do_req(2'b00, 1'b0, 1'b1, 6'd4, 4);
    check_eq("oor_move", m_move, 64'h44);
    check_eq("oor_pause", m_pause, 64'h1FF);
    check_eq("oor_done", m_done, 64'h200);
    check_eq("oor_err", 64'(err_at_done), 64'(1));
    check_eq("oor_tap_rx", 64'(tap_rx), 64'(2));

    // Zero-count step
    do_req(2'b00, 1'b0, 1'b1, 6'd0, -1);
    check_eq("cnt0_done", m_done, 64'h1);
    check_eq("cnt0_pause", m_pause, 64'h0);
    check_eq("cnt0_err", 64'(err_at_done), 64'(0));

    // Reserved op
    do_req(2'b10, 1'b0, 1'b1, 6'd3, -1);
    check_eq("rsv_done", m_done, 64'h1);
    check_eq("rsv_pause", m_pause, 64'h0);
    check_eq("rsv_move", m_move, 64'h0);
    check_eq("rsv_err", 64'(err_at_done), 64'(1));

    // Reset in the middle of a step on RX (tap_rx is 2)
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_sel   = 1'b0;
    req_dir   = 1'b1;
    req_count = 6'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("mid_pause_before", 64'(pause), 64'(1));
    check_eq("mid_move_before", 64'(dl_move), 64'(1));
    #1 rst = 1'b1;
    #1;
    check_eq("mid_pause_drop", 64'(pause), 64'(0));
    check_eq("mid_move_drop", 64'(dl_move), 64'(0));
    check_eq("mid_taps", 64'({tap_rx, tap_tx}), 64'({7'd1, 7'd1}));
    check_eq("mid_ready", 64'(req_ready), 64'(1));
    done_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done || pause) done_seen++;
    end
    check_eq("mid_no_done", 64'(done_seen), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
